// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: decides per cycle which decoder ways go to the EU,
// hands out pID tags in order and tracks in-flight destinations for RAW stalls.
module dual_issue_scheduler #(
  parameter int NUM_PID = 4,
  parameter int PID_W   = 2,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              way0_valid_i,
  input  logic [REG_AW-1:0] way0_rs1Addr_i,
  input  logic [REG_AW-1:0] way0_rs2Addr_i,
  input  logic              way0_rs1ReadEnable_i,
  input  logic              way0_rs2ReadEnable_i,
  input  logic [REG_AW-1:0] way0_rdAddr_i,
  input  logic              way0_rdWriteEnable_i,
  output logic              way0_ready_o,
  input  logic              way1_valid_i,
  input  logic [REG_AW-1:0] way1_rs1Addr_i,
  input  logic [REG_AW-1:0] way1_rs2Addr_i,
  input  logic              way1_rs1ReadEnable_i,
  input  logic              way1_rs2ReadEnable_i,
  input  logic [REG_AW-1:0] way1_rdAddr_i,
  input  logic              way1_rdWriteEnable_i,
  output logic              way1_ready_o,
  input  logic              eu_ready_i,
  output logic              way0_issue_o,
  output logic [PID_W-1:0]  way0_pID_o,
  output logic              way1_issue_o,
  output logic [PID_W-1:0]  way1_pID_o,
  input  logic              wb_valid_i,
  input  logic [PID_W-1:0]  wb_pID_i,
  input  logic              flush_i,
  output logic              sb_full_o
);

  typedef enum logic {ST_PAIR, ST_W1ONLY} state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [NUM_PID-1:0] r_busy;
  logic [NUM_PID-1:0] r_wr;
  logic [REG_AW-1:0]  r_rd [NUM_PID];
  logic [PID_W-1:0]   r_ptr;
  logic               r_issue0;
  logic               r_issue1;
  logic [PID_W-1:0]   r_pid0;
  logic [PID_W-1:0]   r_pid1;

  logic               w_go;
  logic [PID_W-1:0]   w_ptr1;
  logic [PID_W-1:0]   w_ptrW1;
  logic               w_free0;
  logic               w_free1;
  logic               w_haz0;
  logic               w_haz1;
  logic               w_intra;
  logic               w_issue0;
  logic               w_issue1;

  // Nothing is accepted while reset is held so every output reads 0 in reset.
  assign w_go    = eu_ready_i & ~flush_i & rst_n;
  assign w_ptr1  = r_ptr + PID_W'(1);
  assign w_free0 = ~r_busy[r_ptr];
  assign w_free1 = ~r_busy[w_ptr1];
  assign w_ptrW1 = w_issue0 ? w_ptr1 : r_ptr;

  always_comb begin
    w_haz0 = 1'b0;
    w_haz1 = 1'b0;
    for (int p = 0; p < NUM_PID; p++) begin
      if (r_busy[p] && r_wr[p]) begin
        if (way0_rs1ReadEnable_i && (way0_rs1Addr_i != '0) && (way0_rs1Addr_i == r_rd[p]))
          w_haz0 = 1'b1;
        if (way0_rs2ReadEnable_i && (way0_rs2Addr_i != '0) && (way0_rs2Addr_i == r_rd[p]))
          w_haz0 = 1'b1;
        if (way1_rs1ReadEnable_i && (way1_rs1Addr_i != '0) && (way1_rs1Addr_i == r_rd[p]))
          w_haz1 = 1'b1;
        if (way1_rs2ReadEnable_i && (way1_rs2Addr_i != '0) && (way1_rs2Addr_i == r_rd[p]))
          w_haz1 = 1'b1;
      end
    end
  end

  // Younger way reading the older way's destination inside the same pair.
  assign w_intra = way0_rdWriteEnable_i && (way0_rdAddr_i != '0) &&
                   ((way1_rs1ReadEnable_i && (way1_rs1Addr_i == way0_rdAddr_i)) ||
                    (way1_rs2ReadEnable_i && (way1_rs2Addr_i == way0_rdAddr_i)));

  always_comb begin
    w_issue0    = 1'b0;
    w_issue1    = 1'b0;
    w_stateNext = r_state;
    case (r_state)
      ST_PAIR: begin
        w_issue0 = w_go && way0_valid_i && !w_haz0 && w_free0;
        if (w_issue0) begin
          w_issue1 = way1_valid_i && !w_haz1 && !w_intra && w_free1;
          if (way1_valid_i && !w_issue1)
            w_stateNext = ST_W1ONLY;
        end else if (!way0_valid_i) begin
          w_issue1 = w_go && way1_valid_i && !w_haz1 && w_free0;
        end
      end
      ST_W1ONLY: begin
        w_issue1 = w_go && way1_valid_i && !w_haz1 && w_free0;
        if (w_issue1)
          w_stateNext = ST_PAIR;
      end
      default: w_stateNext = ST_PAIR;
    endcase
    if (flush_i)
      w_stateNext = ST_PAIR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_PAIR;
    else
      r_state <= w_stateNext;
  end

  // Writeback clears only busy entries; allocation only targets free ones,
  // so the two never touch the same entry in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_wr   <= '0;
      r_ptr  <= '0;
      for (int p = 0; p < NUM_PID; p++)
        r_rd[p] <= '0;
    end else if (flush_i) begin
      r_busy <= '0;
      r_ptr  <= '0;
    end else begin
      if (wb_valid_i && r_busy[wb_pID_i])
        r_busy[wb_pID_i] <= 1'b0;
      if (w_issue0) begin
        r_busy[r_ptr] <= 1'b1;
        r_rd[r_ptr]   <= way0_rdAddr_i;
        r_wr[r_ptr]   <= way0_rdWriteEnable_i;
      end
      if (w_issue1) begin
        r_busy[w_ptrW1] <= 1'b1;
        r_rd[w_ptrW1]   <= way1_rdAddr_i;
        r_wr[w_ptrW1]   <= way1_rdWriteEnable_i;
      end
      if (w_issue0 && w_issue1)
        r_ptr <= r_ptr + PID_W'(2);
      else if (w_issue0 || w_issue1)
        r_ptr <= w_ptr1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue0 <= 1'b0;
      r_issue1 <= 1'b0;
      r_pid0   <= '0;
      r_pid1   <= '0;
    end else begin
      r_issue0 <= w_issue0;
      r_issue1 <= w_issue1;
      if (w_issue0)
        r_pid0 <= r_ptr;
      if (w_issue1)
        r_pid1 <= w_ptrW1;
    end
  end

  assign way0_ready_o = w_issue0;
  assign way1_ready_o = w_issue1;
  assign way0_issue_o = r_issue0;
  assign way1_issue_o = r_issue1;
  assign way0_pID_o   = r_pid0;
  assign way1_pID_o   = r_pid1;
  assign sb_full_o    = &r_busy;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench for dual_issue_scheduler: hand-derived vector table,
// async-reset sequence, then random traffic against an in-flight-list model.
module tb_dual_issue_scheduler;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       re1;
    logic       re2;
    logic [4:0] rd;
    logic       we;
  } instr_t;

  typedef struct {
    instr_t     i0;
    instr_t     i1;
    logic       eu;
    logic       wbv;
    logic [1:0] wbp;
    logic       fl;
    logic       r0;
    logic       r1;
    logic       full;
    logic       iss0;
    logic       iss1;
    logic [1:0] pid0;
    logic [1:0] pid1;
  } vec_t;

  typedef struct {
    logic [1:0] pid;
    logic [4:0] rd;
    logic       we;
  } rec_t;

  logic       clk;
  logic       rst_n;
  logic       way0_valid_i, way1_valid_i;
  logic [4:0] way0_rs1Addr_i, way0_rs2Addr_i, way0_rdAddr_i;
  logic [4:0] way1_rs1Addr_i, way1_rs2Addr_i, way1_rdAddr_i;
  logic       way0_rs1ReadEnable_i, way0_rs2ReadEnable_i, way0_rdWriteEnable_i;
  logic       way1_rs1ReadEnable_i, way1_rs2ReadEnable_i, way1_rdWriteEnable_i;
  logic       way0_ready_o, way1_ready_o;
  logic       eu_ready_i;
  logic       way0_issue_o, way1_issue_o;
  logic [1:0] way0_pID_o, way1_pID_o;
  logic       wb_valid_i;
  logic [1:0] wb_pID_i;
  logic       flush_i;
  logic       sb_full_o;

  int nChecks = 0;
  int nFail   = 0;

  rec_t       inflight[$];
  int         nextPid;
  logic [1:0] heldPid0, heldPid1;

  dual_issue_scheduler #(.NUM_PID(4), .PID_W(2), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .way0_valid_i(way0_valid_i), .way0_rs1Addr_i(way0_rs1Addr_i), .way0_rs2Addr_i(way0_rs2Addr_i),
    .way0_rs1ReadEnable_i(way0_rs1ReadEnable_i), .way0_rs2ReadEnable_i(way0_rs2ReadEnable_i),
    .way0_rdAddr_i(way0_rdAddr_i), .way0_rdWriteEnable_i(way0_rdWriteEnable_i), .way0_ready_o(way0_ready_o),
    .way1_valid_i(way1_valid_i), .way1_rs1Addr_i(way1_rs1Addr_i), .way1_rs2Addr_i(way1_rs2Addr_i),
    .way1_rs1ReadEnable_i(way1_rs1ReadEnable_i), .way1_rs2ReadEnable_i(way1_rs2ReadEnable_i),
    .way1_rdAddr_i(way1_rdAddr_i), .way1_rdWriteEnable_i(way1_rdWriteEnable_i), .way1_ready_o(way1_ready_o),
    .eu_ready_i(eu_ready_i),
    .way0_issue_o(way0_issue_o), .way0_pID_o(way0_pID_o),
    .way1_issue_o(way1_issue_o), .way1_pID_o(way1_pID_o),
    .wb_valid_i(wb_valid_i), .wb_pID_i(wb_pID_i), .flush_i(flush_i),
    .sb_full_o(sb_full_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic instr_t ins(input int rd, input int rs1, input int rs2);
    instr_t x;
    x.v = 1'b1; x.rd = 5'(rd); x.we = 1'b1;
    x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.re1 = 1'b1; x.re2 = 1'b1;
    return x;
  endfunction

  function automatic instr_t nop();
    instr_t x;
    x.v = 1'b0; x.rd = '0; x.we = 1'b0;
    x.rs1 = '0; x.rs2 = '0; x.re1 = 1'b0; x.re2 = 1'b0;
    return x;
  endfunction

  function automatic instr_t randInstr();
    instr_t x;
    x.v   = ($urandom_range(0, 9) != 0);
    x.rd  = 5'($urandom_range(0, 7));
    x.we  = ($urandom_range(0, 3) != 0);
    x.rs1 = 5'($urandom_range(0, 7));
    x.rs2 = 5'($urandom_range(0, 7));
    x.re1 = ($urandom_range(0, 3) != 0);
    x.re2 = ($urandom_range(0, 3) != 0);
    return x;
  endfunction

  function automatic vec_t mk(input instr_t a, input instr_t b, input bit eu, input bit wbv,
                              input int wbp, input bit fl, input bit r0, input bit r1,
                              input bit full, input bit iss0, input bit iss1,
                              input int p0, input int p1);
    vec_t v;
    v.i0 = a; v.i1 = b; v.eu = eu; v.wbv = wbv; v.wbp = 2'(wbp); v.fl = fl;
    v.r0 = r0; v.r1 = r1; v.full = full; v.iss0 = iss0; v.iss1 = iss1;
    v.pid0 = 2'(p0); v.pid1 = 2'(p1);
    return v;
  endfunction

  task automatic applyStimulus(input instr_t a, input instr_t b, input logic eu,
                               input logic wbv, input logic [1:0] wbp, input logic fl);
    way0_valid_i = a.v; way0_rs1Addr_i = a.rs1; way0_rs2Addr_i = a.rs2;
    way0_rs1ReadEnable_i = a.re1; way0_rs2ReadEnable_i = a.re2;
    way0_rdAddr_i = a.rd; way0_rdWriteEnable_i = a.we;
    way1_valid_i = b.v; way1_rs1Addr_i = b.rs1; way1_rs2Addr_i = b.rs2;
    way1_rs1ReadEnable_i = b.re1; way1_rs2ReadEnable_i = b.re2;
    way1_rdAddr_i = b.rd; way1_rdWriteEnable_i = b.we;
    eu_ready_i = eu; wb_valid_i = wbv; wb_pID_i = wbp; flush_i = fl;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a list of in-flight instructions tagged with their pID.
  function automatic bit srcHit(input logic [4:0] s, input logic en);
    if (!en || s == 0) return 1'b0;
    foreach (inflight[k])
      if (inflight[k].we && inflight[k].rd == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit mHazard(input instr_t x);
    return srcHit(x.rs1, x.re1) || srcHit(x.rs2, x.re2);
  endfunction

  function automatic bit mInUse(input int pid);
    foreach (inflight[k])
      if (int'(inflight[k].pid) == pid) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit mDep(input instr_t a, input instr_t b);
    if (!a.we || a.rd == 0) return 1'b0;
    return (b.re1 && b.rs1 == a.rd) || (b.re2 && b.rs2 == a.rd);
  endfunction

  task automatic doReset();
    applyStimulus(nop(), nop(), 1'b0, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b0;
    #12;
    checkOutput("reset issue0", int'(way0_issue_o), 0);
    checkOutput("reset issue1", int'(way1_issue_o), 0);
    checkOutput("reset pid0", int'(way0_pID_o), 0);
    checkOutput("reset pid1", int'(way1_pID_o), 0);
    checkOutput("reset full", int'(sb_full_o), 0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    inflight.delete();
    nextPid = 0; heldPid0 = 2'd0; heldPid1 = 2'd0;
  endtask

  vec_t   tbl[20];
  instr_t d0, d1;

  initial begin
    rst_n = 1'b0;

    tbl[0]  = mk(ins(5,1,2),  ins(6,1,2),  1,0,0,0, 1,1,0, 1,1, 0,1);
    tbl[1]  = mk(ins(7,1,2),  ins(8,7,1),  1,0,0,0, 1,0,0, 1,0, 2,0);
    tbl[2]  = mk(ins(7,1,2),  ins(8,7,1),  1,0,0,0, 0,0,0, 0,0, 0,0);
    tbl[3]  = mk(ins(7,1,2),  ins(8,7,1),  1,1,2,0, 0,0,0, 0,0, 0,0);
    tbl[4]  = mk(ins(7,1,2),  ins(8,7,1),  1,0,0,0, 0,1,0, 0,1, 0,3);
    tbl[5]  = mk(ins(9,1,2),  ins(10,3,4), 0,1,0,0, 0,0,0, 0,0, 0,0);
    tbl[6]  = mk(ins(9,1,2),  ins(10,3,4), 0,1,1,0, 0,0,0, 0,0, 0,0);
    tbl[7]  = mk(ins(9,1,2),  ins(10,3,4), 1,0,0,0, 1,1,0, 1,1, 0,1);
    tbl[8]  = mk(ins(11,1,2), ins(12,1,2), 1,0,0,0, 1,0,0, 1,0, 2,0);
    tbl[9]  = mk(ins(11,1,2), ins(12,1,2), 1,1,2,0, 0,0,1, 0,0, 0,0);
    tbl[10] = mk(ins(11,1,2), ins(12,1,2), 1,1,3,0, 0,0,0, 0,0, 0,0);
    tbl[11] = mk(ins(11,1,2), ins(12,1,2), 1,0,0,0, 0,1,0, 0,1, 0,3);
    tbl[12] = mk(ins(13,1,2), ins(14,13,1),1,1,0,0, 0,0,0, 0,0, 0,0);
    tbl[13] = mk(ins(13,1,2), ins(14,13,1),1,0,0,0, 1,0,0, 1,0, 0,0);
    tbl[14] = mk(ins(13,1,2), ins(14,13,1),1,1,1,1, 0,0,0, 0,0, 0,0);
    tbl[15] = mk(ins(5,1,2),  ins(6,3,4),  1,0,0,0, 1,1,0, 1,1, 0,1);
    tbl[16] = mk(ins(0,1,2),  ins(7,0,0),  1,0,0,0, 1,1,0, 1,1, 2,3);
    tbl[17] = mk(nop(),       ins(9,5,0),  1,1,0,0, 0,0,1, 0,0, 0,0);
    tbl[18] = mk(nop(),       ins(9,5,0),  1,0,0,0, 0,1,0, 0,1, 0,0);
    tbl[19] = mk(ins(20,6,1), ins(21,1,2), 1,0,0,0, 0,0,1, 0,0, 0,0);

    doReset();

    for (int r = 0; r < 20; r++) begin
      applyStimulus(tbl[r].i0, tbl[r].i1, tbl[r].eu, tbl[r].wbv, tbl[r].wbp, tbl[r].fl);
      #4;
      checkOutput($sformatf("row%0d ready0", r), int'(way0_ready_o), int'(tbl[r].r0));
      checkOutput($sformatf("row%0d ready1", r), int'(way1_ready_o), int'(tbl[r].r1));
      checkOutput($sformatf("row%0d full", r), int'(sb_full_o), int'(tbl[r].full));
      @(posedge clk); #1;
      checkOutput($sformatf("row%0d issue0", r), int'(way0_issue_o), int'(tbl[r].iss0));
      checkOutput($sformatf("row%0d issue1", r), int'(way1_issue_o), int'(tbl[r].iss1));
      if (tbl[r].iss0)
        checkOutput($sformatf("row%0d pid0", r), int'(way0_pID_o), int'(tbl[r].pid0));
      if (tbl[r].iss1)
        checkOutput($sformatf("row%0d pid1", r), int'(way1_pID_o), int'(tbl[r].pid1));
    end

    // Async reset while a pair is being issued, then a fresh pair restarts at pID 0.
    doReset();
    applyStimulus(ins(5,1,2), ins(6,1,2), 1'b1, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #1;
    applyStimulus(ins(7,1,2), ins(8,3,4), 1'b1, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #1;
    checkOutput("pre-reset issue1", int'(way1_issue_o), 1);
    checkOutput("pre-reset pid1", int'(way1_pID_o), 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async issue0", int'(way0_issue_o), 0);
    checkOutput("async issue1", int'(way1_issue_o), 0);
    checkOutput("async pid1", int'(way1_pID_o), 0);
    checkOutput("async ready0", int'(way0_ready_o), 0);
    checkOutput("async ready1", int'(way1_ready_o), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post-reset issue0", int'(way0_issue_o), 1);
    checkOutput("post-reset issue1", int'(way1_issue_o), 1);
    checkOutput("post-reset pid0", int'(way0_pID_o), 0);
    checkOutput("post-reset pid1", int'(way1_pID_o), 1);

    // Random traffic; the decoder holds each way until it is accepted.
    doReset();
    d0 = randInstr(); d1 = randInstr();
    for (int c = 0; c < 3000; c++) begin
      logic eu, wbv, fl, a0, a1, full;
      logic [1:0] wbp;
      eu  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 39) == 0);
      wbv = 1'b0; wbp = 2'd0;
      if (inflight.size() > 0 && $urandom_range(0, 9) < 4) begin
        wbv = 1'b1;
        wbp = inflight[$urandom_range(0, inflight.size() - 1)].pid;
      end else if ($urandom_range(0, 9) == 0) begin
        wbv = 1'b1;
        wbp = 2'($urandom_range(0, 3));
      end
      applyStimulus(d0, d1, eu, wbv, wbp, fl);

      full = (inflight.size() == 4);
      a0 = eu && !fl && d0.v && !mHazard(d0) && !mInUse(nextPid);
      if (a0)
        a1 = d1.v && !mHazard(d1) && !mDep(d0, d1) && !mInUse((nextPid + 1) % 4);
      else
        a1 = !d0.v && eu && !fl && d1.v && !mHazard(d1) && !mInUse(nextPid);

      #4;
      checkOutput($sformatf("rnd%0d ready0", c), int'(way0_ready_o), int'(a0));
      checkOutput($sformatf("rnd%0d ready1", c), int'(way1_ready_o), int'(a1));
      checkOutput($sformatf("rnd%0d full", c), int'(sb_full_o), int'(full));
      @(posedge clk); #1;

      if (fl) begin
        inflight.delete();
        nextPid = 0;
      end else begin
        if (wbv) begin
          for (int k = 0; k < inflight.size(); k++)
            if (inflight[k].pid == wbp) begin
              inflight.delete(k);
              break;
            end
        end
        if (a0) begin
          inflight.push_back('{pid: 2'(nextPid), rd: d0.rd, we: d0.we});
          heldPid0 = 2'(nextPid);
          nextPid = (nextPid + 1) % 4;
        end
        if (a1) begin
          inflight.push_back('{pid: 2'(nextPid), rd: d1.rd, we: d1.we});
          heldPid1 = 2'(nextPid);
          nextPid = (nextPid + 1) % 4;
        end
      end
      checkOutput($sformatf("rnd%0d issue0", c), int'(way0_issue_o), int'(a0));
      checkOutput($sformatf("rnd%0d issue1", c), int'(way1_issue_o), int'(a1));
      checkOutput($sformatf("rnd%0d pid0", c), int'(way0_pID_o), int'(heldPid0));
      checkOutput($sformatf("rnd%0d pid1", c), int'(way1_pID_o), int'(heldPid1));

      if (fl) begin
        d0 = randInstr(); d1 = randInstr();
      end else begin
        if (a0) d0.v = 1'b0;
        if (a1) d1.v = 1'b0;
        if (!d0.v && !d1.v) begin
          d0 = randInstr(); d1 = randInstr();
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
- Issue scheduler between the two decoder ways (way0 = older, way1 = younger) and the EU.
- Decides each cycle whether to issue both, way0 only, way1 only, or neither.
- Allocates the 2-bit pID tag for each issued instruction and tracks in-flight destination registers in a pID-indexed scoreboard.
- Stalls on RAW hazards, intra-pair dependency, full scoreboard or EU back-pressure; frees entries on writeback.

Parameters:
- NUM_PID, 4, scoreboard entries; pID width is log2(NUM_PID).
- PID_W, 2, pID tag width.
- REG_AW, 5, architectural register address width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- wayN_valid_i  in  1  decoded instruction present (N = 0, 1)
- wayN_rs1Addr_i, wayN_rs2Addr_i  in  REG_AW  source addresses
- wayN_rs1ReadEnable_i, wayN_rs2ReadEnable_i  in  1  source used
- wayN_rdAddr_i  in  REG_AW  destination
- wayN_rdWriteEnable_i  in  1  destination written
- wayN_ready_o  out  1  instruction accepted this cycle
- eu_ready_i  in  1  EU can take issues this cycle
- wayN_issue_o  out  1  registered issue pulse to EU
- wayN_pID_o  out  PID_W  pID of the issued instruction (registered)
- wb_valid_i  in  1  writeback completion
- wb_pID_i  in  PID_W  pID being retired
- flush_i  in  1  pipeline flush
- sb_full_o  out  1  all scoreboard entries busy

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0.
  - Scoreboard valid bits cleared.
  - Allocation pointer = 0.
  - FSM = PAIR.
- Scoreboard entry[p] holds {busy, rd, wr}.
  - An entry hazards a source when busy & wr & rd == src & src != 0 & read-enable is set.
- Hazard checks use the registered table state at the start of the cycle. A same-cycle writeback does not unblock until the next cycle.
- Allocation:
  - pIDs are handed out in order from the pointer, which wraps modulo NUM_PID.
  - Allocating requires entry[ptr].busy = 0; if way1 also issues, entry[ptr+1].busy = 0 as well.
  - sb_full_o = all entries busy.
- FSM:
  - PAIR: both ways pending.
  - W1ONLY: way0 of the current pair has issued; way1 still pending.
- Issue rules in PAIR (all require eu_ready_i = 1 and flush_i = 0):
  - way0 issues if valid, no hazard and a free entry is available.
  - way1 issues in the same cycle only if way0 issues, way1 has no scoreboard hazard, way1 sources do not match way0 rd (when way0 rdWriteEnable and rd != 0), and a second free entry is available.
  - If way0 issues and way1 is valid but not issued -> go to W1ONLY.
  - If way0 is invalid, way1 may issue alone (same checks, one entry).
- W1ONLY:
  - way0_ready_o = 0.
  - way1 issues when there is no hazard against the table (which now includes way0's entry), eu_ready_i = 1 and an entry is free; then -> PAIR.
- Handshake:
  - wayN_ready_o = issue decision, combinational, in the same cycle.
  - The decoder holds valid and fields until ready.
- Latency:
  - wayN_issue_o and wayN_pID_o are registered one cycle after acceptance.
  - They are 0 in cycles with no issue; the pID holds its last value.
- On issue:
  - entry[ptr] <= {1, rd, rdWriteEnable}; ptr advances by the number issued.
  - way0 always takes the lower pID.
- On wb_valid_i, entry[wb_pID_i].busy <= 0.
  - A writeback to a non-busy entry is ignored.
  - Allocation never targets a busy entry, so allocate and clear never collide on the same entry.
- flush_i:
  - Synchronously clears all busy bits, ptr <= 0, FSM <= PAIR.
  - Suppresses any issue and ready in that cycle.
  - Registered issue outputs are 0 in the following cycle.
  - flush_i has priority over wb_valid_i.
- rd = x0 or rdWriteEnable = 0 still consumes a pID but never hazards.

Test Plan:
- Independent pair:
  - Stimulus: way0 add x5, way1 add x6 (sources x1/x2), empty table, eu_ready_i = 1.
  - Response: both ready same cycle; next cycle issue_o = 11, pIDs 0 and 1; sb entries 0 and 1 busy.
- Intra-pair RAW:
  - Stimulus: way0 writes x5, way1 reads x5.
  - Response: cycle 0 way0_ready = 1, way1_ready = 0, FSM -> W1ONLY. way1 stays blocked until wb_pID = 0 arrives. It issues the cycle after that writeback with pID 1.
- Scoreboard full:
  - Stimulus: issue 4 instructions with no writeback, then present a fifth.
  - Response: sb_full_o = 1, ready = 0. After wb_pID = 2, the next issue still waits because ptr = 0 is busy. After wb_pID = 0, it issues with pID 0 (wrap).
- Back-pressure:
  - Stimulus: eu_ready_i = 0 for 3 cycles with a valid pair.
  - Response: no ready, no issue pulses, ptr unchanged. Pair issues on the first cycle eu_ready_i = 1.
- Flush mid-pair:
  - Stimulus: in W1ONLY with entries 0..2 busy, assert flush_i together with wb_valid_i (pID 1).
  - Response: next cycle all busy = 0, ptr = 0, FSM = PAIR, issue_o = 00.
- Async reset:
  - Stimulus: drop rst_n mid-cycle while issue_o = 11.
  - Response: outputs go to 0 immediately; after release the first pair gets pIDs 0 and 1.
